// File: rtl/vec_regfile_defs.sv
// Shared vector register file definitions.
// Holds the register file geometry, the SEW encoding used on the writeback path and the
// writeback collector state type. vlmax() returns the element count that fills one register
// at a given SEW.
package vec_regfile_defs;

    localparam int unsigned VLEN                = 512;
    localparam int unsigned ADDR_WIDTH          = 5;
    localparam int unsigned DATA_WIDTH          = VLEN;
    localparam int unsigned NO_OF_VEC_REGISTERS = 32;
    localparam int unsigned ELEM_W              = 64;
    localparam int unsigned VL_W                = $clog2(VLEN / 8) + 1;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10,
        SEW64 = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } wb_state_e;

    // VLEN / SEW, with SEW = 8 << sew
    function automatic logic [VL_W-1:0] vlmax(input sew_e sew);
        return VL_W'((VLEN / 8) >> sew);
    endfunction

endpackage

// File: rtl/vec_elem_insert.sv
// Combinational element insert.
// Replaces the SEW-wide slot at element index idx_i of buf_i with the low SEW bits of data_i.
// Ports:
//   buf_i   current packed vector
//   data_i  lane result (only the low SEW bits are used)
//   idx_i   element index, always < VLEN/SEW
//   sew_i   element width encoding (00=8 .. 11=64)
//   buf_o   vector with the slot replaced
module vec_elem_insert
    import vec_regfile_defs::*;
(
    input  logic [DATA_WIDTH-1:0] buf_i,
    input  logic [ELEM_W-1:0]     data_i,
    input  logic [VL_W-1:0]       idx_i,
    input  logic [1:0]            sew_i,
    output logic [DATA_WIDTH-1:0] buf_o
);

    logic [ELEM_W-1:0]     elem_mask;
    logic [VL_W+2:0]       bit_off;
    logic [DATA_WIDTH-1:0] slot_mask;
    logic [DATA_WIDTH-1:0] slot_data;

    always_comb begin
        case (sew_i)
            2'b00:   elem_mask = 64'h0000_0000_0000_00FF;
            2'b01:   elem_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   elem_mask = 64'h0000_0000_FFFF_FFFF;
            default: elem_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        // idx * SEW; cannot overflow because idx < VLEN/SEW
        bit_off   = {idx_i, 3'b000} << sew_i;
        slot_mask = DATA_WIDTH'(elem_mask) << bit_off;
        slot_data = DATA_WIDTH'(data_i & elem_mask) << bit_off;
        buf_o     = (buf_i & ~slot_mask) | slot_data;
    end

endmodule

// File: rtl/vec_wb_collector.sv
// Vector writeback collector.
// Accepts lane results over a valid/ready stream, packs them at the latched SEW into one
// VLEN-wide vector and issues a single-cycle register file write to vd. Tail elements are
// zero filled. vl is clamped to VLMAX; a clamped vl of 0 only pulses done_o.
// Ports:
//   clk, reset                    clock and asynchronous active-low reset
//   start_i, vd_i, sew_i, vl_i    operation request, sampled in IDLE only
//   busy_o                        high outside IDLE
//   elem_valid_i/elem_data_i      lane result stream
//   elem_ready_o                  high while collecting
//   wr_en, waddr, wdata           registered one-cycle register file write
//   done_o                        registered one-cycle completion pulse
module vec_wb_collector
    import vec_regfile_defs::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] vd_i,
    input  logic [1:0]            sew_i,
    input  logic [VL_W-1:0]       vl_i,
    output logic                  busy_o,
    input  logic                  elem_valid_i,
    input  logic [ELEM_W-1:0]     elem_data_i,
    output logic                  elem_ready_o,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  done_o
);

    wb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] vd_q, vd_d;
    sew_e                  sew_q, sew_d;
    logic [VL_W-1:0]       vl_q, vl_d;
    logic [VL_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] vec_q, vec_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;

    logic [VL_W-1:0]       vl_max;
    logic [VL_W-1:0]       vl_eff;
    logic [DATA_WIDTH-1:0] vec_ins;

    vec_elem_insert u_insert (
        .buf_i  (vec_q),
        .data_i (elem_data_i),
        .idx_i  (cnt_q),
        .sew_i  (sew_q),
        .buf_o  (vec_ins)
    );

    always_comb begin
        vl_max = vlmax(sew_e'(sew_i));
        vl_eff = (vl_i < vl_max) ? vl_i : vl_max;

        state_d = state_q;
        vd_d    = vd_q;
        sew_d   = sew_q;
        vl_d    = vl_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        wr_en_d = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    vd_d  = vd_i;
                    sew_d = sew_e'(sew_i);
                    vl_d  = vl_eff;
                    cnt_d = '0;
                    vec_d = '0;
                    if (vl_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (elem_valid_i) begin
                    vec_d = vec_ins;
                    cnt_d = cnt_q + VL_W'(1);
                    if (cnt_q == vl_q - VL_W'(1)) begin
                        // Write outputs are loaded on the last handshake edge so wr_en
                        // is visible in the very next cycle.
                        state_d = WRITE;
                        wr_en_d = 1'b1;
                        waddr_d = vd_q;
                        wdata_d = vec_ins;
                        done_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            vd_q    <= '0;
            sew_q   <= SEW8;
            vl_q    <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vd_q    <= vd_d;
            sew_q   <= sew_d;
            vl_q    <= vl_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign elem_ready_o = (state_q == COLLECT);
    assign wr_en        = wr_en_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_vec_wb_collector.sv
module tb_vec_wb_collector;
    import vec_regfile_defs::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start_i = 1'b0;
    logic [ADDR_WIDTH-1:0] vd_i = '0;
    logic [1:0]            sew_i = '0;
    logic [VL_W-1:0]       vl_i = '0;
    logic                  busy_o;
    logic                  elem_valid_i = 1'b0;
    logic [ELEM_W-1:0]     elem_data_i = '0;
    logic                  elem_ready_o;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  done_o;

    always #5 clk = ~clk;

    vec_wb_collector dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .vd_i         (vd_i),
        .sew_i        (sew_i),
        .vl_i         (vl_i),
        .busy_o       (busy_o),
        .elem_valid_i (elem_valid_i),
        .elem_data_i  (elem_data_i),
        .elem_ready_o (elem_ready_o),
        .wr_en        (wr_en),
        .waddr        (waddr),
        .wdata        (wdata),
        .done_o       (done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_vec(input string name, input logic [DATA_WIDTH-1:0] act,
                           input logic [DATA_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a transaction is either collecting elements into a queue or
    // presenting its packed vector for one cycle.
    bit                    m_collect = 0;
    bit                    m_write   = 0;
    int                    m_n       = 0;
    int                    m_sew_bits = 8;
    logic [ADDR_WIDTH-1:0] m_vd = '0;
    logic [63:0]           m_got[$];
    logic                  m_wr = 1'b0;
    logic                  m_done = 1'b0;
    logic [ADDR_WIDTH-1:0] m_addr = '0;
    logic [DATA_WIDTH-1:0] m_data = '0;

    initial begin : model
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_collect = 0;
                m_write   = 0;
                m_wr      = 1'b0;
                m_done    = 1'b0;
                m_addr    = '0;
                m_data    = '0;
                m_got.delete();
            end else begin
                m_wr   = 1'b0;
                m_done = 1'b0;
                m_addr = '0;
                m_data = '0;
                if (m_write) begin
                    m_write = 0;
                end else if (m_collect) begin
                    if (elem_valid_i) begin
                        m_got.push_back(elem_data_i);
                        if (m_got.size() == m_n) begin
                            m_collect = 0;
                            m_write   = 1;
                            m_wr      = 1'b1;
                            m_done    = 1'b1;
                            m_addr    = m_vd;
                            for (int i = 0; i < m_n; i++)
                                for (int b = 0; b < m_sew_bits; b++)
                                    m_data[i*m_sew_bits+b] = m_got[i][b];
                        end
                    end
                end else if (start_i) begin
                    m_sew_bits = 8 << sew_i;
                    m_n = (int'(vl_i) < VLEN / m_sew_bits) ? int'(vl_i) : VLEN / m_sew_bits;
                    m_vd = vd_i;
                    m_got.delete();
                    if (m_n == 0) m_done = 1'b1;
                    else m_collect = 1;
                end
            end
        end
    end

    int                    wr_cnt = 0;
    int                    done_cnt = 0;
    bit                    busy_seen = 0;
    logic [ADDR_WIDTH-1:0] last_addr = '0;
    logic [DATA_WIDTH-1:0] last_data = '0;
    logic                  last_done = 1'b0;

    initial begin : compare
        forever begin
            @(negedge clk);
            chk_bit("wr_en", wr_en, m_wr);
            chk_vec("waddr", DATA_WIDTH'(waddr), DATA_WIDTH'(m_addr));
            chk_vec("wdata", wdata, m_data);
            chk_bit("done_o", done_o, m_done);
            chk_bit("busy_o", busy_o, m_collect | m_write);
            chk_bit("elem_ready_o", elem_ready_o, m_collect);
            if (wr_en === 1'b1) begin
                wr_cnt++;
                last_addr = waddr;
                last_data = wdata;
                last_done = done_o;
            end
            if (done_o === 1'b1) done_cnt++;
            if (busy_o === 1'b1) busy_seen = 1;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int vd, input int sew, input int vl);
        start_i = 1'b1;
        vd_i    = ADDR_WIDTH'(vd);
        sew_i   = 2'(sew);
        vl_i    = VL_W'(vl);
        tick();
        start_i = 1'b0;
    endtask

    // Offers one element; ok reports whether it was accepted within max_wait cycles.
    task automatic send(input logic [63:0] d, input int gap_pct, input int max_wait,
                        output bit ok);
        int waited = 0;
        while (int'($urandom_range(99)) < gap_pct) begin
            elem_valid_i = 1'b0;
            elem_data_i  = {$urandom, $urandom};
            tick();
        end
        elem_valid_i = 1'b1;
        elem_data_i  = d;
        ok = 0;
        while (!ok && waited < max_wait) begin
            ok = elem_ready_o;
            tick();
            waited++;
        end
        elem_valid_i = 1'b0;
    endtask

    logic [DATA_WIDTH-1:0] exp_vec;
    logic [31:0]           e32[4];
    int                    base_wr;
    int                    base_done;
    int                    accepted;
    bit                    ok;

    initial begin : driver
        e32[0] = 32'h11; e32[1] = 32'h22; e32[2] = 32'h33; e32[3] = 32'h44;

        // Reset state
        repeat (3) tick();
        chk_bit("reset_wr_en", wr_en, 1'b0);
        chk_bit("reset_busy", busy_o, 1'b0);
        chk_bit("reset_ready", elem_ready_o, 1'b0);
        chk_vec("reset_wdata", wdata, '0);
        reset = 1'b1;
        tick();

        // 1: sew32, vl=4, back-to-back
        base_wr = wr_cnt;
        start_op(3, 2, 4);
        for (int i = 0; i < 4; i++) begin
            send({32'h0, e32[i]}, 0, 4, ok);
            chk_bit("t1_handshake", ok, 1'b1);
        end
        repeat (3) tick();
        exp_vec = DATA_WIDTH'(128'h00000044_00000033_00000022_00000011);
        chk_int("t1_write_count", wr_cnt - base_wr, 1);
        chk_vec("t1_waddr", DATA_WIDTH'(last_addr), DATA_WIDTH'(3));
        chk_vec("t1_wdata", last_data, exp_vec);
        chk_bit("t1_done_with_wr", last_done, 1'b1);

        // 2: same with valid gaps
        base_wr = wr_cnt;
        start_op(3, 2, 4);
        for (int i = 0; i < 4; i++) begin
            send({32'h0, e32[i]}, 50, 4, ok);
            chk_bit("t2_handshake", ok, 1'b1);
        end
        repeat (3) tick();
        chk_int("t2_write_count", wr_cnt - base_wr, 1);
        chk_vec("t2_wdata", last_data, exp_vec);

        // 3: vl=0
        base_wr   = wr_cnt;
        base_done = done_cnt;
        busy_seen = 0;
        start_op(5, 1, 0);
        repeat (3) tick();
        chk_int("t3_done_count", done_cnt - base_done, 1);
        chk_int("t3_write_count", wr_cnt - base_wr, 0);
        chk_bit("t3_busy_seen", busy_seen, 1'b0);

        // 4: sew8, vl=80 clamps to 64; upper data bits are garbage and must be dropped
        base_wr  = wr_cnt;
        accepted = 0;
        start_op(9, 0, 80);
        for (int i = 0; i < 80; i++) begin
            send({$urandom, 24'($urandom), 8'(i)}, 0, 1, ok);
            if (!ok) break;
            accepted++;
        end
        repeat (3) tick();
        chk_int("t4_accepted", accepted, 64);
        exp_vec = '0;
        for (int i = 0; i < 64; i++) exp_vec[i*8 +: 8] = 8'(i);
        chk_int("t4_write_count", wr_cnt - base_wr, 1);
        chk_vec("t4_wdata", last_data, exp_vec);
        chk_vec("t4_waddr", DATA_WIDTH'(last_addr), DATA_WIDTH'(9));

        // 5: reset after 2 of 4 elements, then a fresh full transfer
        base_wr = wr_cnt;
        start_op(4, 2, 4);
        send(64'h11, 0, 4, ok);
        send(64'h22, 0, 4, ok);
        reset = 1'b0;
        #1;
        chk_bit("t5_busy_async", busy_o, 1'b0);
        chk_bit("t5_ready_async", elem_ready_o, 1'b0);
        chk_bit("t5_wr_en_async", wr_en, 1'b0);
        chk_bit("t5_done_async", done_o, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk_int("t5_no_write", wr_cnt - base_wr, 0);
        start_op(4, 2, 4);
        for (int i = 0; i < 4; i++) send({32'hDEAD_BEEF, e32[i] + 32'hA0}, 30, 4, ok);
        repeat (3) tick();
        exp_vec = DATA_WIDTH'(128'h000000E4_000000D3_000000C2_000000B1);
        chk_int("t5_write_count", wr_cnt - base_wr, 1);
        chk_vec("t5_wdata", last_data, exp_vec);

        // 6: start during collection is ignored
        base_wr = wr_cnt;
        start_op(2, 3, 3);
        send(64'h0123_4567_89AB_CDEF, 0, 4, ok);
        start_i = 1'b1;
        vd_i    = ADDR_WIDTH'(7);
        vl_i    = VL_W'(1);
        send(64'hFEDC_BA98_7654_3210, 0, 4, ok);
        start_i = 1'b0;
        send(64'h5555_AAAA_0F0F_F0F0, 0, 4, ok);
        repeat (3) tick();
        exp_vec = DATA_WIDTH'({64'h5555_AAAA_0F0F_F0F0, 64'hFEDC_BA98_7654_3210,
                               64'h0123_4567_89AB_CDEF});
        chk_int("t6_write_count", wr_cnt - base_wr, 1);
        chk_vec("t6_waddr", DATA_WIDTH'(last_addr), DATA_WIDTH'(2));
        chk_vec("t6_wdata", last_data, exp_vec);

        // Random traffic, occasional async reset, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            start_i      = ($urandom_range(7) == 0);
            vd_i         = ADDR_WIDTH'($urandom);
            sew_i        = 2'($urandom);
            vl_i         = ($urandom_range(9) == 0) ? '0 : VL_W'($urandom_range(1, 90));
            elem_valid_i = ($urandom_range(2) != 0);
            elem_data_i  = {$urandom, $urandom};
            reset        = ($urandom_range(399) != 0);
            tick();
        end
        reset        = 1'b1;
        start_i      = 1'b0;
        elem_valid_i = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
